// File: rtl/tx_arbiter_pkg.sv
// Shared definitions for the TX arbiter: command width, reply-owner encoding,
// FSM state and grant encodings.
package tx_arbiter_pkg;

  // Default width of a TX command word.
  localparam int TX_CMD_BITS = 16;

  // Reply-owner encoding stored in the owner FIFO.
  localparam logic OWNER_PF = 1'b0;
  localparam logic OWNER_SC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_PF = 2'd1,
    ST_BUSY_SC = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PF   = 2'd1,
    GNT_SC   = 2'd2
  } grant_t;

endpackage

// File: rtl/tx_arbiter_owner_fifo.sv
// tx_owner_fifo: 1-bit wide reply-owner FIFO. Wrap-around read/write pointers
// plus an occupancy count. Pop on empty is dropped; push while full is accepted
// only when a pop happens in the same cycle.
module tx_owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_pop;
  logic             do_push;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: shares the TX command/payload channel between prefetch and the
// scheduler and records which requester owns each outstanding RX reply.
// Optional macro TX_ARB_FAIRNESS_EN: after the scheduler wins over a waiting
// prefetch, the next unreserved grant goes to prefetch.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int NSHIFT      = 2,
  parameter int CMD_BITS    = TX_CMD_BITS,
  parameter int REPLY_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pf_cmd_valid,
  input  logic [CMD_BITS-1:0] pf_cmd,
  output logic                pf_started,
  output logic                pf_rx_sel,
  input  logic                sc_cmd_valid,
  input  logic [CMD_BITS-1:0] sc_cmd,
  input  logic                sc_reserve,
  input  logic                sc_reply_wanted,
  input  logic                sc_block_reply,
  input  logic [NSHIFT-1:0]   sc_data,
  output logic                sc_data_next,
  output logic                sc_started,
  output logic                sc_tx_done,
  output logic                sc_rx_sel,
  output logic                tx_command_valid,
  output logic [CMD_BITS-1:0] tx_command,
  output logic [NSHIFT-1:0]   tx_data,
  input  logic                tx_command_started,
  input  logic                tx_data_next,
  input  logic                tx_done,
  input  logic                rx_done,
  output logic                busy,
  output logic                err_rx
);

  state_t state_q, state_d;
  grant_t gnt_sel;
  logic   fifo_full, fifo_empty, fifo_head;
  logic   push, push_bit;
  logic   sc_needs_reply;
  logic   pf_ok, sc_ok;

`ifdef TX_ARB_FAIRNESS_EN
  logic   fair_q;
`endif

  assign sc_needs_reply = sc_reply_wanted && !sc_block_reply;
  // Every prefetch command expects a reply, so it always needs a free owner slot.
  assign pf_ok = pf_cmd_valid && !sc_reserve && !fifo_full;
  assign sc_ok = sc_cmd_valid && (!sc_needs_reply || !fifo_full);

  // Pick the requester offered to TX while idle.
  always_comb begin
    gnt_sel = GNT_NONE;
`ifdef TX_ARB_FAIRNESS_EN
    if (fair_q && pf_ok) gnt_sel = GNT_PF;
    else
`endif
    if (sc_cmd_valid) gnt_sel = sc_ok ? GNT_SC : GNT_NONE;
    else if (pf_ok)   gnt_sel = GNT_PF;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state, TX channel muxing and handshake pulses.
  always_comb begin
    state_d          = state_q;
    tx_command_valid = 1'b0;
    tx_command       = '0;
    tx_data          = '0;
    pf_started       = 1'b0;
    sc_started       = 1'b0;
    sc_data_next     = 1'b0;
    sc_tx_done       = 1'b0;
    push             = 1'b0;
    push_bit         = OWNER_PF;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_sel != GNT_NONE) begin
          tx_command_valid = 1'b1;
          tx_command       = (gnt_sel == GNT_SC) ? sc_cmd : pf_cmd;
          if (tx_command_started) begin
            if (gnt_sel == GNT_SC) begin
              sc_started = 1'b1;
              state_d    = ST_BUSY_SC;
              push       = sc_needs_reply;
              push_bit   = OWNER_SC;
            end else begin
              pf_started = 1'b1;
              state_d    = ST_BUSY_PF;
              push       = 1'b1;
              push_bit   = OWNER_PF;
            end
          end
        end
      end
      ST_BUSY_PF: begin
        if (tx_done) state_d = ST_IDLE;
      end
      ST_BUSY_SC: begin
        tx_data      = sc_data;
        sc_data_next = tx_data_next;
        if (tx_done) begin
          sc_tx_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky flag: a reply arrived that nobody was waiting for.
  always_ff @(posedge clk) begin
    if (reset)                    err_rx <= 1'b0;
    else if (rx_done && fifo_empty) err_rx <= 1'b1;
  end

`ifdef TX_ARB_FAIRNESS_EN
  // Owe prefetch one grant after the scheduler wins while prefetch waits.
  always_ff @(posedge clk) begin
    if (reset)                                                    fair_q <= 1'b0;
    else if (pf_started)                                          fair_q <= 1'b0;
    else if (sc_started && pf_cmd_valid)                          fair_q <= 1'b1;
  end
`endif

  tx_owner_fifo #(
    .DEPTH (REPLY_DEPTH)
  ) u_owner_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_bit),
    .pop   (rx_done),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign pf_rx_sel = !fifo_empty && (fifo_head == OWNER_PF);
  assign sc_rx_sel = !fifo_empty && (fifo_head == OWNER_SC);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tx_arbiter.sv
// Testbench for tx_arbiter: directed scenarios plus a randomized run checked
// against a queue-based reference model.
module tb_tx_arbiter;

  localparam int NS = 2;
  localparam int CB = 16;
  localparam int RD = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          pf_cmd_valid;
  logic [CB-1:0] pf_cmd;
  logic          pf_started, pf_rx_sel;
  logic          sc_cmd_valid;
  logic [CB-1:0] sc_cmd;
  logic          sc_reserve, sc_reply_wanted, sc_block_reply;
  logic [NS-1:0] sc_data;
  logic          sc_data_next, sc_started, sc_tx_done, sc_rx_sel;
  logic          tx_command_valid;
  logic [CB-1:0] tx_command;
  logic [NS-1:0] tx_data;
  logic          tx_command_started, tx_data_next, tx_done, rx_done;
  logic          busy, err_rx;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tx_arbiter #(.NSHIFT(NS), .CMD_BITS(CB), .REPLY_DEPTH(RD)) dut (
    .clk(clk), .reset(reset),
    .pf_cmd_valid(pf_cmd_valid), .pf_cmd(pf_cmd), .pf_started(pf_started), .pf_rx_sel(pf_rx_sel),
    .sc_cmd_valid(sc_cmd_valid), .sc_cmd(sc_cmd), .sc_reserve(sc_reserve),
    .sc_reply_wanted(sc_reply_wanted), .sc_block_reply(sc_block_reply), .sc_data(sc_data),
    .sc_data_next(sc_data_next), .sc_started(sc_started), .sc_tx_done(sc_tx_done), .sc_rx_sel(sc_rx_sel),
    .tx_command_valid(tx_command_valid), .tx_command(tx_command), .tx_data(tx_data),
    .tx_command_started(tx_command_started), .tx_data_next(tx_data_next), .tx_done(tx_done),
    .rx_done(rx_done), .busy(busy), .err_rx(err_rx)
  );

  task automatic clr_in();
    pf_cmd_valid = 0; pf_cmd = '0; sc_cmd_valid = 0; sc_cmd = '0; sc_reserve = 0;
    sc_reply_wanted = 0; sc_block_reply = 0; sc_data = '0;
    tx_command_started = 0; tx_data_next = 0; tx_done = 0; rx_done = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1; clr_in(); step(); step(); reset = 0;
    @(negedge clk);
    tests++; if ({busy, err_rx, tx_command_valid, pf_started, sc_started, pf_rx_sel, sc_rx_sel, sc_data_next, sc_tx_done} !== 9'b0) begin fails++; $display("FAIL reset_ctrl: got %b exp 0", {busy, err_rx, tx_command_valid, pf_started, sc_started, pf_rx_sel, sc_rx_sel, sc_data_next, sc_tx_done}); end
    tests++; if ({tx_command, tx_data} !== '0) begin fails++; $display("FAIL reset_data: got %h exp 0", {tx_command, tx_data}); end
    step();
  endtask

  task automatic test_pf_basic();
    int bad = 0;
    pf_cmd_valid = 1; pf_cmd = 16'hA5A5;
    for (int c = 0; c < 4; c++) begin
      tx_command_started = (c == 3);
      @(negedge clk);
      if (tx_command_valid !== 1'b1 || tx_command !== 16'hA5A5) bad++;
      if (pf_started !== (c == 3)) bad++;
      step();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL pf_offer: %0d bad cycles exp 0", bad); end
    pf_cmd_valid = 0; tx_command_started = 0;
    @(negedge clk);
    tests++; if ({busy, pf_rx_sel, tx_command_valid, tx_data} !== 5'b11000) begin fails++; $display("FAIL pf_busy: got %b exp 11000", {busy, pf_rx_sel, tx_command_valid, tx_data}); end
    for (int c = 4; c < 10; c++) step();
    tx_done = 1;
    @(negedge clk);
    tests++; if ({busy, sc_tx_done} !== 2'b10) begin fails++; $display("FAIL pf_done: got %b exp 10", {busy, sc_tx_done}); end
    step(); tx_done = 0; rx_done = 1;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL pf_idle: got %b exp 0", busy); end
    step(); rx_done = 0;
    @(negedge clk);
    tests++; if ({pf_rx_sel, err_rx} !== 2'b00) begin fails++; $display("FAIL pf_pop: got %b exp 00", {pf_rx_sel, err_rx}); end
    step();
  endtask

  task automatic test_sc_priority();
    pf_cmd_valid = 1; pf_cmd = 16'h0F0F; sc_cmd_valid = 1; sc_cmd = 16'h1234;
    sc_reply_wanted = 1; tx_command_started = 1;
    @(negedge clk);
    tests++; if ({tx_command, sc_started, pf_started} !== {16'h1234, 2'b10}) begin fails++; $display("FAIL sc_grant: got %h/%b exp 1234/10", tx_command, {sc_started, pf_started}); end
    step();
    pf_cmd_valid = 0; sc_cmd_valid = 0; tx_command_started = 0; sc_data = 2'b10; tx_data_next = 1;
    @(negedge clk);
    tests++; if ({tx_data, sc_data_next, sc_rx_sel, tx_command_valid} !== 5'b10110) begin fails++; $display("FAIL sc_payload: got %b exp 10110", {tx_data, sc_data_next, sc_rx_sel, tx_command_valid}); end
    step(); tx_data_next = 0;
    @(negedge clk);
    tests++; if (sc_data_next !== 1'b0) begin fails++; $display("FAIL sc_next_low: got %b exp 0", sc_data_next); end
    step(); tx_done = 1; pf_cmd_valid = 1;
    @(negedge clk);
    tests++; if ({sc_tx_done, tx_command_valid} !== 2'b10) begin fails++; $display("FAIL sc_done: got %b exp 10", {sc_tx_done, tx_command_valid}); end
    step(); pf_cmd_valid = 0;
    @(negedge clk);
    tests++; if ({sc_tx_done, busy} !== 2'b00) begin fails++; $display("FAIL sc_done_once: got %b exp 00", {sc_tx_done, busy}); end
    step(); tx_done = 0; rx_done = 1; step(); clr_in();
  endtask

  task automatic test_reserve();
    int bad = 0;
    sc_reserve = 1; pf_cmd_valid = 1; pf_cmd = 16'h0077; tx_command_started = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tx_command_valid !== 1'b0 || pf_started !== 1'b0) bad++;
      step();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL reserve_block: %0d bad cycles exp 0", bad); end
    sc_reserve = 0;
    @(negedge clk);
    tests++; if ({tx_command_valid, pf_started} !== 2'b11) begin fails++; $display("FAIL reserve_release: got %b exp 11", {tx_command_valid, pf_started}); end
    step(); clr_in(); tx_done = 1; step(); tx_done = 0; rx_done = 1; step(); rx_done = 0;
  endtask

  task automatic test_fifo_full();
    for (int g = 0; g < 2; g++) begin
      pf_cmd_valid = 1; tx_command_started = 1; step();
      pf_cmd_valid = 0; tx_command_started = 0; tx_done = 1; step(); tx_done = 0;
    end
    pf_cmd_valid = 1; tx_command_started = 1;
    @(negedge clk);
    tests++; if ({tx_command_valid, pf_started, pf_rx_sel} !== 3'b001) begin fails++; $display("FAIL full_block: got %b exp 001", {tx_command_valid, pf_started, pf_rx_sel}); end
    step(); rx_done = 1;
    @(negedge clk);
    tests++; if (tx_command_valid !== 1'b0) begin fails++; $display("FAIL full_pop_cycle: got %b exp 0", tx_command_valid); end
    step();
    @(negedge clk);
    tests++; if ({tx_command_valid, pf_started} !== 2'b11) begin fails++; $display("FAIL pop_push: got %b exp 11", {tx_command_valid, pf_started}); end
    step(); clr_in(); tx_done = 1; step(); tx_done = 0;
    @(negedge clk);
    tests++; if ({pf_rx_sel, busy} !== 2'b10) begin fails++; $display("FAIL one_left: got %b exp 10", {pf_rx_sel, busy}); end
    step(); rx_done = 1; step(); rx_done = 0;
    @(negedge clk);
    tests++; if ({pf_rx_sel, sc_rx_sel, err_rx} !== 3'b000) begin fails++; $display("FAIL drained: got %b exp 000", {pf_rx_sel, sc_rx_sel, err_rx}); end
    step();
  endtask

  task automatic test_err_block();
    int bad = 0;
    rx_done = 1; step(); rx_done = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); if (err_rx !== 1'b1) bad++; step();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL err_sticky: %0d bad cycles exp 0", bad); end
    sc_cmd_valid = 1; sc_reply_wanted = 1; sc_block_reply = 1; tx_command_started = 1;
    @(negedge clk);
    tests++; if (sc_started !== 1'b1) begin fails++; $display("FAIL block_grant: got %b exp 1", sc_started); end
    step(); clr_in();
    @(negedge clk);
    tests++; if ({busy, sc_rx_sel, pf_rx_sel, err_rx} !== 4'b1001) begin fails++; $display("FAIL block_nopush: got %b exp 1001", {busy, sc_rx_sel, pf_rx_sel, err_rx}); end
    tx_done = 1; step(); tx_done = 0; step();
  endtask

  task automatic test_reset_mid();
    sc_cmd_valid = 1; sc_reply_wanted = 1; tx_command_started = 1; step(); clr_in();
    @(negedge clk);
    tests++; if ({busy, sc_rx_sel} !== 2'b11) begin fails++; $display("FAIL mid_pre: got %b exp 11", {busy, sc_rx_sel}); end
    reset = 1; step(); reset = 0; tx_done = 1; tx_data_next = 1; sc_data = 2'b11;
    @(negedge clk);
    tests++; if ({busy, sc_rx_sel, pf_rx_sel, err_rx, sc_tx_done, sc_data_next, sc_started, pf_started, tx_data} !== 10'b0) begin fails++; $display("FAIL mid_reset: got %b exp 0", {busy, sc_rx_sel, pf_rx_sel, err_rx, sc_tx_done, sc_data_next, sc_started, pf_started, tx_data}); end
    step(); clr_in(); step();
  endtask

  task automatic test_fairness();
    int gnt[$];
    int cyc = 0;
    string got_s, exp_s;
    pf_cmd_valid = 1; sc_cmd_valid = 1; tx_command_started = 1; tx_done = 1;
    while (gnt.size() < 3 && cyc < 40) begin
      rx_done = pf_rx_sel | sc_rx_sel;
      @(negedge clk);
      if (sc_started) gnt.push_back(2);
      else if (pf_started) gnt.push_back(1);
      step(); cyc++;
    end
    got_s = "";
    foreach (gnt[i]) got_s = {got_s, (gnt[i] == 2) ? "S" : "P"};
`ifdef TX_ARB_FAIRNESS_EN
    exp_s = "SPS";
`else
    exp_s = "SSS";
`endif
    tests++; if (got_s != exp_s) begin fails++; $display("FAIL grant_order: got %s exp %s", got_s, exp_s); end
    clr_in(); reset = 1; step(); reset = 0; step();
  endtask

  task automatic test_random();
    bit mq[$];
    int m_st = 0;
    bit m_err = 0, m_fair = 0;
    int pick;
    bit cap, need_sc, pf_ok, sc_ok;
    logic [8:0] e_ctrl;
    logic [CB-1:0] e_cmd;
    logic [NS-1:0] e_data;
    reset = 1; clr_in(); step(); reset = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      pf_cmd_valid = $urandom_range(0, 1); pf_cmd = CB'($urandom);
      sc_cmd_valid = $urandom_range(0, 2) == 0; sc_cmd = CB'($urandom);
      sc_reserve = $urandom_range(0, 3) == 0; sc_reply_wanted = $urandom_range(0, 1);
      sc_block_reply = $urandom_range(0, 3) == 0; sc_data = NS'($urandom);
      tx_command_started = $urandom_range(0, 1); tx_data_next = $urandom_range(0, 1);
      tx_done = $urandom_range(0, 3) == 0; rx_done = $urandom_range(0, 3) == 0;
      // Reference: what the spec says should be visible this cycle.
      cap = mq.size() < RD;
      need_sc = sc_reply_wanted && !sc_block_reply;
      pf_ok = pf_cmd_valid && !sc_reserve && cap;
      sc_ok = sc_cmd_valid && (!need_sc || cap);
      pick = 0;
      if (m_st == 0) begin
`ifdef TX_ARB_FAIRNESS_EN
        if (m_fair && pf_ok) pick = 1; else
`endif
        if (sc_cmd_valid) pick = sc_ok ? 2 : 0;
        else if (pf_ok) pick = 1;
      end
      e_cmd = (pick == 2) ? sc_cmd : (pick == 1) ? pf_cmd : '0;
      e_data = (m_st == 2) ? sc_data : '0;
      e_ctrl = {m_st != 0, m_err, pick != 0, pick == 1 && tx_command_started, pick == 2 && tx_command_started,
                mq.size() > 0 && mq[0] == 1'b0, mq.size() > 0 && mq[0] == 1'b1,
                m_st == 2 && tx_data_next, m_st == 2 && tx_done};
      @(negedge clk);
      tests++; if ({busy, err_rx, tx_command_valid, pf_started, sc_started, pf_rx_sel, sc_rx_sel, sc_data_next, sc_tx_done} !== e_ctrl) begin fails++; $display("FAIL rand_ctrl cyc %0d: got %b exp %b", c, {busy, err_rx, tx_command_valid, pf_started, sc_started, pf_rx_sel, sc_rx_sel, sc_data_next, sc_tx_done}, e_ctrl); end
      tests++; if ({tx_command, tx_data} !== {e_cmd, e_data}) begin fails++; $display("FAIL rand_data cyc %0d: got %h/%h exp %h/%h", c, tx_command, tx_data, e_cmd, e_data); end
      // Advance the model across the clock edge.
      if (reset) begin
        mq.delete(); m_st = 0; m_err = 0; m_fair = 0;
      end else begin
        if (rx_done) begin
          if (mq.size() == 0) m_err = 1; else void'(mq.pop_front());
        end
        if (m_st == 0 && pick == 1 && tx_command_started) begin
          mq.push_back(1'b0); m_st = 1; m_fair = 0;
        end else if (m_st == 0 && pick == 2 && tx_command_started) begin
          if (need_sc) mq.push_back(1'b1);
          m_st = 2;
          if (pf_cmd_valid) m_fair = 1;
        end else if (m_st != 0 && tx_done) begin
          m_st = 0;
        end
      end
      step();
    end
    reset = 0; clr_in();
  endtask

  initial begin
    reset = 1; clr_in();
    test_reset();
    test_pf_basic();
    test_sc_priority();
    test_reserve();
    test_fifo_full();
    test_err_block();
    test_reset_mid();
    test_fairness();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
